// File: rtl/program_fetch.sv
// Loadable program store with a registered fetch port that returns {opcode, operand} word pairs.
// A loader fills the store through a valid/ready stream; fetches are checked for alignment and load status.
//
// state | meaning
// EMPTY | after reset, no program image present
// LOAD  | accepting program words in address order
// READY | complete image present, fetches return data
module program_fetch #(
    parameter int WORD_W = 3,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    output logic              loaded,
    input  logic              halt,
    input  logic              fetch_req,
    input  logic [PTR_W-1:0]  instr_ptr,
    output logic [WORD_W-1:0] opcode,
    output logic [WORD_W-1:0] operand,
    output logic              fetch_valid,
    output logic [1:0]        fault
);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);

    state_t            state;
    logic [PTR_W-1:0]  wr_addr;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              fetch_ok;
    logic [PTR_W-1:0]  op_addr;
    logic [PTR_W-1:0]  opnd_addr;

    // A restart takes priority over a coincident word, so the restart cycle writes nothing.
    assign wr_en     = load_ready && load_valid && !load_start;
    assign fetch_ok  = (state == READY) && !load_start;
    assign op_addr   = instr_ptr & ~PTR_W'(1);
    assign opnd_addr = instr_ptr | PTR_W'(1);

    // Program storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            wr_addr     <= '0;
            load_ready  <= 1'b0;
            loaded      <= 1'b0;
            opcode      <= '0;
            operand     <= '0;
            fetch_valid <= 1'b0;
            fault       <= 2'b00;
        end else begin
            fetch_valid <= 1'b0;
            fault       <= 2'b00;
            if (fetch_req && !halt) begin
                if (!fetch_ok) begin
                    fault <= 2'b10;
                end else if (instr_ptr[0]) begin
                    fault <= 2'b01;
                end else begin
                    opcode      <= mem[op_addr];
                    operand     <= mem[opnd_addr];
                    fetch_valid <= 1'b1;
                end
            end

            case (state)
                EMPTY: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wr_addr    <= '0;
                        load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_addr <= '0;
                    end else if (wr_en) begin
                        if (wr_addr == LAST_ADDR) begin
                            wr_addr    <= '0;
                            state      <= READY;
                            load_ready <= 1'b0;
                            loaded     <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wr_addr    <= '0;
                        load_ready <= 1'b1;
                        loaded     <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    wr_addr    <= '0;
                    load_ready <= 1'b0;
                    loaded     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_fetch.sv
// Directed bench for program_fetch: vector table for the fetch port plus hand-written load sequences.
// A second instance covers the DEPTH=8, WORD_W=4 configuration.
module tb_program_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start, load_valid, halt, fetch_req;
    logic [2:0] load_data;
    logic [3:0] instr_ptr;
    logic       load_ready, loaded, fetch_valid;
    logic [2:0] opcode, operand;
    logic [1:0] fault;

    logic       b_load_start, b_load_valid, b_halt, b_fetch_req;
    logic [3:0] b_load_data;
    logic [2:0] b_instr_ptr;
    logic       b_load_ready, b_loaded, b_fetch_valid;
    logic [3:0] b_opcode, b_operand;
    logic [1:0] b_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    program_fetch #(.WORD_W(3), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .loaded(loaded),
        .halt(halt), .fetch_req(fetch_req), .instr_ptr(instr_ptr),
        .opcode(opcode), .operand(operand), .fetch_valid(fetch_valid), .fault(fault)
    );

    program_fetch #(.WORD_W(4), .DEPTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
        .load_ready(b_load_ready), .loaded(b_loaded),
        .halt(b_halt), .fetch_req(b_fetch_req), .instr_ptr(b_instr_ptr),
        .opcode(b_opcode), .operand(b_operand), .fetch_valid(b_fetch_valid), .fault(b_fault)
    );

    typedef struct {
        logic       req;
        logic       hlt;
        logic [3:0] ptr;
        logic       exp_v;
        logic [1:0] exp_f;
        logic [2:0] exp_op;
        logic [2:0] exp_opnd;
    } vec_t;

    function automatic vec_t mk(input int req, input int hlt, input int ptr,
                                input int v, input int f, input int op, input int opnd);
        vec_t r;
        r.req      = 1'(req);
        r.hlt      = 1'(hlt);
        r.ptr      = 4'(ptr);
        r.exp_v    = 1'(v);
        r.exp_f    = 2'(f);
        r.exp_op   = 3'(op);
        r.exp_opnd = 3'(opnd);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[18];
        int img[16];
        int img2[16];
        int bimg[8];
        int hi, acc, cycles, early;

        vecs[0]  = mk(1, 0, 0,  1, 0, 0, 1);
        vecs[1]  = mk(1, 0, 2,  1, 0, 2, 3);
        vecs[2]  = mk(1, 0, 4,  1, 0, 4, 5);
        vecs[3]  = mk(1, 0, 6,  1, 0, 6, 7);
        vecs[4]  = mk(1, 0, 8,  1, 0, 0, 1);
        vecs[5]  = mk(1, 0, 10, 1, 0, 2, 3);
        vecs[6]  = mk(1, 0, 12, 1, 0, 4, 5);
        vecs[7]  = mk(1, 0, 14, 1, 0, 6, 7);
        vecs[8]  = mk(1, 0, 5,  0, 1, 6, 7);
        vecs[9]  = mk(1, 0, 15, 0, 1, 6, 7);
        vecs[10] = mk(0, 0, 0,  0, 0, 6, 7);
        vecs[11] = mk(1, 0, 4,  1, 0, 4, 5);
        vecs[12] = mk(1, 1, 6,  0, 0, 4, 5);
        vecs[13] = mk(1, 1, 6,  0, 0, 4, 5);
        vecs[14] = mk(1, 1, 6,  0, 0, 4, 5);
        vecs[15] = mk(1, 0, 6,  1, 0, 6, 7);
        vecs[16] = mk(1, 1, 5,  0, 0, 6, 7);
        vecs[17] = mk(1, 0, 2,  1, 0, 2, 3);

        for (int k = 0; k < 16; k++) begin
            img[k]  = (3 * k + 1) % 8;
            img2[k] = (k + 5) % 8;
        end
        for (int k = 0; k < 8; k++) bimg[k] = (5 * k + 3) % 16;

        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        halt = 1'b0; fetch_req = 1'b1; instr_ptr = '0;
        b_load_start = 1'b0; b_load_valid = 1'b0; b_load_data = '0;
        b_halt = 1'b0; b_fetch_req = 1'b0; b_instr_ptr = '0;

        // reset with a pending fetch
        tick(); tick();
        chk("rst_fault", fault, 0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_loaded", loaded, 0);
        rst = 1'b0;
        tick();
        chk("empty_fault", fault, 2);
        chk("empty_valid", fetch_valid, 0);
        chk("empty_opcode", opcode, 0);
        chk("empty_operand", operand, 0);
        fetch_req = 1'b0;

        // full load, valid held high
        load_start = 1'b1;
        tick();
        hi = load_ready ? 1 : 0;
        chk("load_start_loaded", loaded, 0);
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            load_data = 3'(k % 8);
            if (k == 15) chk("loaded_before_last", loaded, 0);
            tick();
            if (load_ready) hi++;
        end
        load_valid = 1'b0;
        chk("load_ready_cycles", hi, 16);
        chk("loaded_after_full", loaded, 1);
        chk("load_ready_after_full", load_ready, 0);

        for (int i = 0; i < 18; i++) begin
            fetch_req = vecs[i].req;
            halt      = vecs[i].hlt;
            instr_ptr = vecs[i].ptr;
            tick();
            chk($sformatf("vec%0d_valid", i), fetch_valid, vecs[i].exp_v);
            chk($sformatf("vec%0d_fault", i), fault, vecs[i].exp_f);
            chk($sformatf("vec%0d_opcode", i), opcode, vecs[i].exp_op);
            chk($sformatf("vec%0d_operand", i), operand, vecs[i].exp_opnd);
        end
        fetch_req = 1'b0;
        halt = 1'b0;

        // load with valid toggling
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        acc = 0; cycles = 0; early = 0;
        while (acc < 16 && cycles < 64) begin
            load_valid = (cycles % 2 == 0);
            load_data  = 3'(img[acc]);
            if (loaded) early++;
            hi = (load_valid && load_ready) ? 1 : 0;
            tick();
            acc += hi;
            cycles++;
        end
        load_valid = 1'b0;
        chk("gap_load_cycles", cycles, 31);
        chk("gap_loaded_early", early, 0);
        chk("gap_loaded", loaded, 1);
        fetch_req = 1'b1;
        for (int p = 0; p < 16; p += 2) begin
            instr_ptr = 4'(p);
            tick();
            chk($sformatf("gap_valid_p%0d", p), fetch_valid, 1);
            chk($sformatf("gap_opcode_p%0d", p), opcode, img[p]);
            chk($sformatf("gap_operand_p%0d", p), operand, img[p + 1]);
        end

        // reload with coincident fetch, partial load, restart
        instr_ptr = '0;
        load_start = 1'b1;
        tick();
        chk("reload_fault", fault, 2);
        chk("reload_valid", fetch_valid, 0);
        chk("reload_opcode_hold", opcode, img[14]);
        chk("reload_operand_hold", operand, img[15]);
        chk("reload_load_ready", load_ready, 1);
        chk("reload_loaded", loaded, 0);
        load_start = 1'b0;
        instr_ptr = 4'd2;
        load_valid = 1'b1;
        load_data = 3'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) chk("fetch_in_load_fault", fault, 2);
        end
        fetch_req = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            load_data = 3'(img2[k]);
            if (k == 15) chk("restart_loaded_before_last", loaded, 0);
            tick();
        end
        load_valid = 1'b0;
        chk("restart_loaded", loaded, 1);
        fetch_req = 1'b1;
        for (int p = 0; p < 16; p += 2) begin
            instr_ptr = 4'(p);
            tick();
            chk($sformatf("new_valid_p%0d", p), fetch_valid, 1);
            chk($sformatf("new_opcode_p%0d", p), opcode, img2[p]);
            chk($sformatf("new_operand_p%0d", p), operand, img2[p + 1]);
        end
        fetch_req = 1'b0;

        // reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("abort_load_ready", load_ready, 0);
        chk("abort_loaded", loaded, 0);
        fetch_req = 1'b1;
        instr_ptr = '0;
        tick();
        chk("abort_fetch_fault", fault, 2);
        chk("abort_fetch_valid", fetch_valid, 0);
        fetch_req = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("abort_no_autoload", loaded, 0);
        load_valid = 1'b0;

        // DEPTH=8, WORD_W=4 instance
        b_load_start = 1'b1;
        tick();
        chk("b_load_ready", b_load_ready, 1);
        b_load_start = 1'b0;
        b_load_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_load_data = 4'(bimg[k]);
            if (k == 7) chk("b_loaded_before_last", b_loaded, 0);
            tick();
        end
        b_load_valid = 1'b0;
        chk("b_loaded", b_loaded, 1);
        b_fetch_req = 1'b1;
        for (int p = 0; p < 8; p += 2) begin
            b_instr_ptr = 3'(p);
            tick();
            chk($sformatf("b_valid_p%0d", p), b_fetch_valid, 1);
            chk($sformatf("b_opcode_p%0d", p), b_opcode, bimg[p]);
            chk($sformatf("b_operand_p%0d", p), b_operand, bimg[p + 1]);
        end
        b_instr_ptr = 3'd3;
        tick();
        chk("b_unaligned_fault", b_fault, 1);
        chk("b_unaligned_valid", b_fetch_valid, 0);
        chk("b_unaligned_opcode", b_opcode, bimg[6]);
        b_instr_ptr = 3'd2;
        b_load_start = 1'b1;
        tick();
        chk("b_reload_fault", b_fault, 2);
        chk("b_reload_loaded", b_loaded, 0);
        b_load_start = 1'b0;
        b_fetch_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b_abort_load_ready", b_load_ready, 0);
        chk("b_abort_loaded", b_loaded, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_fetch.md
# program_fetch

Parametrised, run-time loadable instruction fetch stage for the small-ISA CPU. A loader writes a DEPTH-word program image into internal storage over a valid/ready stream. The fetch side then returns registered {opcode, operand} word pairs at even instruction pointers, and flags unaligned pointers and fetches issued before a program is loaded. It sits between the external program-load interface and the decode/execute stage, replacing fixed compile-time program constants.

## Interface
Parameters:
- WORD_W, 3, width of one program word (opcode and operand are each one word)
- DEPTH, 16, program words stored; must be even and >= 2
- PTR_W, $clog2(DEPTH), instruction pointer width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse; enter LOAD, write address := 0, loaded := 0
- load_valid  in  1  load_data holds a valid program word
- load_data  in  WORD_W  program word, written in address order 0..DEPTH-1
- load_ready  out  1  accepting words (high only in LOAD)
- loaded  out  1  complete image present (high only in READY)
- halt  in  1  freeze fetch outputs; fetch_req ignored
- fetch_req  in  1  request a pair at instr_ptr
- instr_ptr  in  PTR_W  word address of the opcode
- opcode  out  WORD_W  mem[instr_ptr], registered
- operand  out  WORD_W  mem[instr_ptr+1], registered
- fetch_valid  out  1  one-cycle pulse: opcode/operand updated with a good pair
- fault  out  2  registered with fetch response; bit0 = unaligned pointer, bit1 = not loaded

## Operation
- States: EMPTY (reset), LOAD, READY.
- EMPTY: load_ready=0, loaded=0. load_start -> LOAD.
- LOAD: load_ready=1. A word is accepted when load_valid && load_ready: mem[wr_addr] := load_data, then wr_addr++.
  - Accepting word DEPTH-1 -> READY next cycle; wr_addr wraps to 0.
  - load_start in LOAD restarts at address 0. Already-written words remain but are overwritten.
- READY: loaded=1. load_start -> LOAD (loaded drops next cycle).
- Fetch response is evaluated when fetch_req && !halt:
  - Not READY: fault=2'b10, fetch_valid=0, opcode/operand hold.
  - READY and instr_ptr[0]=1: fault=2'b01, fetch_valid=0, opcode/operand hold.
  - READY and instr_ptr even: opcode := mem[ptr], operand := mem[ptr+1], fetch_valid=1, fault=0.
- fetch_req=0 or halt=1: fetch_valid=0, fault=0, opcode/operand hold.
- halt does not affect loading.
- A cycle with load_start=1 in READY is treated as not READY for a coincident fetch_req, which returns fault=2'b10.
- Pointer DEPTH-2 is the last legal pair. No wrap past DEPTH-1 is possible because odd pointers fault.
- Memory contents are not reset. Only state, wr_addr and the outputs are reset.

## Timing
- Reset (rst sampled high) forces: state=EMPTY, wr_addr=0, load_ready=0, loaded=0, opcode=0, operand=0, fetch_valid=0, fault=0.
- Reset mid-LOAD aborts the load. A new load_start is needed to load again.
- Fetch latency is 1 cycle: request at edge N, response visible after edge N+1. Back-to-back requests are accepted every cycle.
- load_ready and loaded are registered from state, so they change the cycle after the transition edge.
- Minimum load time is DEPTH cycles with load_valid held high. loaded rises the cycle after the last word is accepted.
- A fetch in the first READY cycle returns the freshly loaded data. There is no read-before-write hazard, because writes stop on entry to READY.

## Test plan
- Reset/idle: assert rst 2 cycles, then fetch_req ptr=0 -> all outputs 0 during reset; after reset fault=2'b10, fetch_valid=0, opcode=operand=0.
- Full load and sweep: DEPTH=16, load words k%8 (k=0..15) with valid held high -> load_ready high for 16 cycles, loaded=1 after; fetch ptr 0,2,...,14 back-to-back -> fetch_valid each cycle, opcode=ptr%8, operand=(ptr+1)%8.
- Backpressure gaps: load with load_valid toggling 1,0,1... -> exactly 16 writes, contents correct, loaded rises only after the 16th accepted word.
- Unaligned pointer: READY, fetch ptr=5 -> fault=2'b01, fetch_valid=0, opcode/operand keep the previous pair; ptr=15 -> same fault.
- Halt: READY, fetch ptr=4 then assert halt with fetch_req ptr=6 for 3 cycles -> outputs hold the ptr-4 pair, fetch_valid=0, fault=0; release -> ptr-6 pair after 1 cycle.
- Reload and abort: in READY, load_start with a coincident fetch -> fault=2'b10; write 5 words then load_start again, write 16 new words -> fetches return only the new image. rst during LOAD -> EMPTY, loaded=0. Repeat with DEPTH=8, WORD_W=4.
